// File: rtl/proc_debug_controller.sv
// Run/halt/dump controller. It enables the processor for a programmed number of cycles,
// waits for the pipeline to drain, then streams the register file followed by the data
// memory over a valid/ready port.
module proc_debug_controller #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned REG_COUNT    = 8,
  parameter int unsigned MEM_DEPTH    = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned CYCLE_W      = 16,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic               main_clk,
  input  logic               restart,
  input  logic               start,
  input  logic [CYCLE_W-1:0] run_cycles,
  input  logic               resume_req,
  output logic               controller_enable,
  output logic               proc_resume,
  output logic               rd_sel,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [DATA_W-1:0]  dump_data,
  output logic               dump_is_mem,
  output logic [ADDR_W-1:0]  dump_index,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StRdIssue,
    StRdCapt,
    StPresent,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0]  RegLast   = ADDR_W'(REG_COUNT - 1);
  localparam logic [ADDR_W-1:0]  MemLast   = ADDR_W'(MEM_DEPTH - 1);
  // The run counter is reused to time the drain; a zero drain still costs one cycle.
  localparam logic [CYCLE_W-1:0] DrainLoad = CYCLE_W'(DRAIN_CYCLES);

  state_e              state_q, state_d;
  logic [CYCLE_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                dump_valid_q, dump_valid_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                dump_is_mem_q, dump_is_mem_d;
  logic [ADDR_W-1:0]   dump_index_q, dump_index_d;
  logic                resume_prev_q;
  logic                proc_resume_q, proc_resume_d;
  logic [ADDR_W-1:0]   last_idx;

  assign last_idx = rd_sel_q ? MemLast : RegLast;

  // Next-state logic for the run/drain/dump sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    rd_sel_d      = rd_sel_q;
    rd_addr_d     = rd_addr_q;
    dump_valid_d  = dump_valid_q;
    dump_data_d   = dump_data_q;
    dump_is_mem_d = dump_is_mem_q;
    dump_index_d  = dump_index_q;
    // Edge-detected so a held request yields a single pulse.
    proc_resume_d = (state_q == StRun) && resume_req && !resume_prev_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          rd_sel_d = 1'b0;
          idx_d    = '0;
          if (run_cycles == '0) begin
            cnt_d   = DrainLoad;
            state_d = StDrain;
          end else begin
            cnt_d   = run_cycles;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (cnt_q <= CYCLE_W'(1)) begin
          cnt_d   = DrainLoad;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q <= CYCLE_W'(1)) begin
          rd_sel_d  = 1'b0;
          idx_d     = '0;
          rd_addr_d = '0;
          state_d   = StRdIssue;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRdIssue: begin
        state_d = StRdCapt;
      end
      StRdCapt: begin
        dump_data_d   = rd_data;
        dump_is_mem_d = rd_sel_q;
        dump_index_d  = idx_q;
        dump_valid_d  = 1'b1;
        state_d       = StPresent;
      end
      StPresent: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q < last_idx) begin
            idx_d     = idx_q + 1'b1;
            rd_addr_d = idx_q + 1'b1;
            state_d   = StRdIssue;
          end else if (!rd_sel_q) begin
            rd_sel_d  = 1'b1;
            idx_d     = '0;
            rd_addr_d = '0;
            state_d   = StRdIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; restart wins over everything and drops any pending word.
  always_ff @(posedge main_clk) begin
    if (restart) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      rd_sel_q      <= 1'b0;
      rd_addr_q     <= '0;
      dump_valid_q  <= 1'b0;
      dump_data_q   <= '0;
      dump_is_mem_q <= 1'b0;
      dump_index_q  <= '0;
      resume_prev_q <= 1'b0;
      proc_resume_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      rd_sel_q      <= rd_sel_d;
      rd_addr_q     <= rd_addr_d;
      dump_valid_q  <= dump_valid_d;
      dump_data_q   <= dump_data_d;
      dump_is_mem_q <= dump_is_mem_d;
      dump_index_q  <= dump_index_d;
      resume_prev_q <= resume_req;
      proc_resume_q <= proc_resume_d;
    end
  end

  // Output decode.
  always_comb begin
    controller_enable = (state_q == StRun);
    busy              = (state_q != StIdle) && (state_q != StDone);
    done              = (state_q == StDone);
    proc_resume       = proc_resume_q;
    rd_sel            = rd_sel_q;
    rd_addr           = rd_addr_q;
    dump_valid        = dump_valid_q;
    dump_data         = dump_data_q;
    dump_is_mem       = dump_is_mem_q;
    dump_index        = dump_index_q;
  end

endmodule

// File: tb/tb_proc_debug_controller.sv
// Self-checking bench for proc_debug_controller: default configuration plus a wide
// 16/16/64 instance; dump words are scoreboarded against preloaded array models.
module tb_proc_debug_controller;

  localparam int unsigned CW    = 16;
  localparam int unsigned DRAIN = 4;
  localparam int unsigned DW1 = 8,  RC1 = 8,  MD1 = 16, AW1 = 4;
  localparam int unsigned DW2 = 16, RC2 = 16, MD2 = 64, AW2 = 6;

  typedef struct packed {
    logic        is_mem;
    logic [7:0]  idx;
    logic [15:0] data;
  } word_t;

  logic main_clk = 1'b0;
  logic restart;

  logic           start, resume_req, dump_ready;
  logic [CW-1:0]  run_cycles;
  logic           controller_enable, proc_resume, rd_sel, dump_valid, dump_is_mem, busy, done;
  logic [AW1-1:0] rd_addr, dump_index;
  logic [DW1-1:0] rd_data, dump_data;

  logic           start2, resume_req2, dump_ready2;
  logic [CW-1:0]  run_cycles2;
  logic           controller_enable2, proc_resume2, rd_sel2, dump_valid2, dump_is_mem2;
  logic           busy2, done2;
  logic [AW2-1:0] rd_addr2, dump_index2;
  logic [DW2-1:0] rd_data2, dump_data2;

  logic [DW1-1:0] regs1 [RC1];
  logic [DW1-1:0] mem1  [MD1];
  logic [DW2-1:0] regs2 [RC2];
  logic [DW2-1:0] mem2  [MD2];

  word_t exp_q1 [$];
  word_t exp_q2 [$];
  int total = 0, bad = 0;
  int words1 = 0, words2 = 0;
  int en_cnt, en_first, en_last, vfirst, pulses;
  bit finished;

  always #5 main_clk = ~main_clk;

  proc_debug_controller #(
    .DATA_W(DW1), .REG_COUNT(RC1), .MEM_DEPTH(MD1), .ADDR_W(AW1),
    .CYCLE_W(CW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .main_clk(main_clk), .restart(restart), .start(start), .run_cycles(run_cycles),
    .resume_req(resume_req), .controller_enable(controller_enable), .proc_resume(proc_resume),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_is_mem(dump_is_mem),
    .dump_index(dump_index), .busy(busy), .done(done)
  );

  proc_debug_controller #(
    .DATA_W(DW2), .REG_COUNT(RC2), .MEM_DEPTH(MD2), .ADDR_W(AW2),
    .CYCLE_W(CW), .DRAIN_CYCLES(DRAIN)
  ) dut2 (
    .main_clk(main_clk), .restart(restart), .start(start2), .run_cycles(run_cycles2),
    .resume_req(resume_req2), .controller_enable(controller_enable2),
    .proc_resume(proc_resume2), .rd_sel(rd_sel2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .dump_valid(dump_valid2), .dump_ready(dump_ready2), .dump_data(dump_data2),
    .dump_is_mem(dump_is_mem2), .dump_index(dump_index2), .busy(busy2), .done(done2)
  );

  // Synchronous-read array models: data valid one cycle after the address.
  always @(posedge main_clk) rd_data  <= rd_sel  ? mem1[rd_addr]  : regs1[rd_addr[2:0]];
  always @(posedge main_clk) rd_data2 <= rd_sel2 ? mem2[rd_addr2] : regs2[rd_addr2[3:0]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs1();
    return 64'({controller_enable, proc_resume, rd_sel, rd_addr, dump_valid, dump_data,
                dump_is_mem, dump_index, busy, done});
  endfunction

  // Scoreboard pop on every accepted word; an empty queue yields an impossible sentinel.
  always @(negedge main_clk) begin
    word_t g, w;
    if (!restart && dump_valid && dump_ready) begin
      w = '1;
      if (exp_q1.size() != 0) w = exp_q1.pop_front();
      g.is_mem = dump_is_mem;
      g.idx    = 8'(dump_index);
      g.data   = 16'(dump_data);
      check_eq("dump1_word", 64'(g), 64'(w));
      words1++;
    end
  end

  always @(negedge main_clk) begin
    word_t g, w;
    if (!restart && dump_valid2 && dump_ready2) begin
      w = '1;
      if (exp_q2.size() != 0) w = exp_q2.pop_front();
      g.is_mem = dump_is_mem2;
      g.idx    = 8'(dump_index2);
      g.data   = 16'(dump_data2);
      check_eq("dump2_word", 64'(g), 64'(w));
      words2++;
    end
  end

  task automatic cyc();
    @(posedge main_clk);
    #1;
  endtask

  task automatic load_and_expect1();
    word_t w;
    foreach (regs1[k]) regs1[k] = DW1'($urandom);
    foreach (mem1[k])  mem1[k]  = DW1'($urandom);
    for (int r = 0; r < int'(RC1); r++) begin
      w.is_mem = 1'b0; w.idx = 8'(r); w.data = 16'(regs1[r]);
      exp_q1.push_back(w);
    end
    for (int m = 0; m < int'(MD1); m++) begin
      w.is_mem = 1'b1; w.idx = 8'(m); w.data = 16'(mem1[m]);
      exp_q1.push_back(w);
    end
  endtask

  task automatic load_and_expect2();
    word_t w;
    foreach (regs2[k]) regs2[k] = DW2'($urandom);
    foreach (mem2[k])  mem2[k]  = DW2'($urandom);
    for (int r = 0; r < int'(RC2); r++) begin
      w.is_mem = 1'b0; w.idx = 8'(r); w.data = 16'(regs2[r]);
      exp_q2.push_back(w);
    end
    for (int m = 0; m < int'(MD2); m++) begin
      w.is_mem = 1'b1; w.idx = 8'(m); w.data = 16'(mem2[m]);
      exp_q2.push_back(w);
    end
  endtask

  // One full run on the default DUT with optional resume window, stall and abort.
  task automatic do_run(input int run_len, input int res_lo, input int res_hi,
                        input int stall_idx, input int abort_idx);
    bit stalled;
    logic [DW1-1:0] hold_d;
    int i;
    en_cnt = 0; en_first = 0; en_last = 0; vfirst = 0; pulses = 0; finished = 0;
    stalled = 0; words1 = 0;
    load_and_expect1();
    start = 1'b1; run_cycles = CW'(run_len); dump_ready = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("busy_done_after_start", 64'({busy, done}), 64'(2'b10));
    i = 1;
    while (i < 400 && !finished) begin
      if (controller_enable) begin
        en_cnt++;
        if (en_first == 0) en_first = i;
        en_last = i;
      end
      if (proc_resume) pulses++;
      if (dump_valid && vfirst == 0) vfirst = i;
      if (done) finished = 1;
      resume_req = (i >= res_lo && i <= res_hi);
      if (dump_valid && !dump_is_mem && int'(dump_index) == stall_idx && !stalled) begin
        stalled = 1;
        dump_ready = 1'b0;
        hold_d = dump_data;
        for (int k = 0; k < 10; k++) begin
          cyc();
          i++;
          check_eq("stall_valid", 64'(dump_valid), 64'(1));
          check_eq("stall_data", 64'(dump_data), 64'(hold_d));
          check_eq("stall_index", 64'(dump_index), 64'(stall_idx));
        end
        dump_ready = 1'b1;
      end
      if (dump_valid && dump_is_mem && int'(dump_index) == abort_idx) begin
        dump_ready = 1'b0;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check_eq("abort_outs", outs1(), 64'(0));
        return;
      end
      if (!finished) begin
        cyc();
        i++;
      end
    end
    resume_req = 1'b0;
  endtask

  task automatic verify_run(input int run_len, input int exp_pulses);
    check_eq("en_count", 64'(en_cnt), 64'(run_len));
    check_eq("en_first", 64'(en_first), 64'(run_len > 0 ? 1 : 0));
    check_eq("en_last", 64'(en_last), 64'(run_len));
    check_eq("dump_start", 64'(vfirst), 64'(run_len + int'(DRAIN) + 3));
    check_eq("resume_pulses", 64'(pulses), 64'(exp_pulses));
    check_eq("finished", 64'(finished), 64'(1));
    check_eq("word_count", 64'(words1), 64'(RC1 + MD1));
    check_eq("queue_empty", 64'(exp_q1.size()), 64'(0));
    check_eq("done_busy", 64'({done, busy}), 64'(2'b10));
  endtask

  initial begin
    restart = 1'b1; start = 1'b0; run_cycles = '0; resume_req = 1'b0; dump_ready = 1'b0;
    start2 = 1'b0; run_cycles2 = '0; resume_req2 = 1'b0; dump_ready2 = 1'b0;
    repeat (3) cyc();
    check_eq("reset_outs", outs1(), 64'(0));
    restart = 1'b0;
    cyc();
    check_eq("idle_outs", outs1(), 64'(0));

    do_run(5, 0, 0, -1, -1);
    verify_run(5, 0);

    do_run(0, 0, 0, -1, -1);
    verify_run(0, 0);

    // Held resume during RUN plus a 10-cycle stall on register word 3.
    do_run(10, 2, 4, 3, -1);
    verify_run(10, 1);

    // Resume requested only while draining.
    do_run(3, 5, 6, -1, -1);
    verify_run(3, 0);

    // Restart while memory word 7 is presented, then replay from scratch.
    do_run(2, 0, 0, -1, 7);
    check_eq("abort_words", 64'(words1), 64'(RC1 + 7));
    exp_q1.delete();
    do_run(1, 0, 0, -1, -1);
    verify_run(1, 0);

    // Wide instance with random back-pressure.
    words2 = 0;
    load_and_expect2();
    start2 = 1'b1; run_cycles2 = CW'(3);
    cyc();
    start2 = 1'b0;
    for (int i = 0; i < 3000 && !done2; i++) begin
      dump_ready2 = 1'($urandom_range(0, 1));
      cyc();
    end
    dump_ready2 = 1'b0;
    check_eq("wide_done", 64'(done2), 64'(1));
    check_eq("wide_words", 64'(words2), 64'(RC2 + MD2));
    check_eq("wide_queue_empty", 64'(exp_q2.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
